hd_timing_gen: RTL and testbench



---
 rtl/hd_timing_gen.sv | 149 ++++++++++++++
 tb/tb_hd_timing_gen.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hd_timing_gen.sv
// rtl/hd_timing_gen.sv - HD raster timing generator, frame-locked to the PAL source
//
// Purpose: divides clk into a pixel strobe with a phase accumulator and runs
// horizontal/vertical raster counters off its falling edge. It decodes
// hsync/vsync/de from the counters and can re-phase the vertical counter to
// LOCK_LINE when the PAL source signals the end of a frame.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   i_frame_end    one-cycle pulse, end of PAL frame
//   i_lock_en      enables frame lock
//   o_hd_clk       pixel strobe; its falling edge is the pixel advance
//   o_hd_hsync     horizontal sync, active high
//   o_hd_vsync     vertical sync, active high
//   o_hd_de        active video
//   o_h_count      current pixel column
//   o_v_count      current line
//   o_frame_start  one-cycle pulse when the raster enters (0,0)
//   o_locked       last lock event found the raster already in phase
module hd_timing_gen #(
    parameter int H_ACTIVE  = 1280,
    parameter int H_FP      = 440,
    parameter int H_SYNC    = 40,
    parameter int H_BP      = 220,
    parameter int V_ACTIVE  = 720,
    parameter int V_FP      = 5,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 20,
    parameter int PIX_INC   = 1,
    parameter int PIX_MOD   = 1,
    parameter int LOCK_LINE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_frame_end,
    input  logic        i_lock_en,
    output logic        o_hd_clk,
    output logic        o_hd_hsync,
    output logic        o_hd_vsync,
    output logic        o_hd_de,
    output logic [11:0] o_h_count,
    output logic [10:0] o_v_count,
    output logic        o_frame_start,
    output logic        o_locked
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    logic [15:0] acc_q, acc_d;
    logic        hd_clk_q, hd_clk_d;
    logic [11:0] h_q, h_d;
    logic [10:0] v_q, v_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        de_q, de_d;
    logic        frame_start_q, frame_start_d;
    logic        locked_q, locked_d;
    logic        lock_req_q, lock_req_d;

    logic [16:0] sum;
    logic        tick;
    logic        pix_adv;
    logic        line_end;
    logic        lock_pending;
    logic        lock_take;
    logic [10:0] v_norm;

    always_comb begin
        // 17-bit sum so a large increment cannot wrap before the compare
        sum   = {1'b0, acc_q} + 17'(PIX_INC);
        tick  = (sum >= 17'(PIX_MOD));
        acc_d = tick ? 16'(sum - 17'(PIX_MOD)) : sum[15:0];

        hd_clk_d = hd_clk_q ^ tick;
        // a tick while the strobe is high is its falling edge
        pix_adv  = tick & hd_clk_q;
        line_end = pix_adv & (h_q == 12'(H_TOTAL - 1));

        // a frame-end pulse coinciding with the line end counts immediately
        lock_pending = lock_req_q | i_frame_end;
        lock_take    = line_end & lock_pending & i_lock_en;

        v_norm = (v_q == 11'(V_TOTAL - 1)) ? 11'd0 : v_q + 11'd1;

        h_d      = h_q;
        v_d      = v_q;
        locked_d = locked_q;
        if (pix_adv) begin
            h_d = line_end ? 12'd0 : h_q + 12'd1;
        end
        if (line_end) begin
            v_d = lock_take ? 11'(LOCK_LINE) : v_norm;
        end
        if (lock_take) begin
            locked_d = (v_norm == 11'(LOCK_LINE));
        end

        // request survives only while lock is enabled and no line end has taken it
        lock_req_d = i_lock_en & ~line_end & lock_pending;

        frame_start_d = pix_adv & (h_d == 12'd0) & (v_d == 11'd0);

        hsync_d = (h_d >= 12'(HS_START)) && (h_d < 12'(HS_END));
        vsync_d = (v_d >= 11'(VS_START)) && (v_d < 11'(VS_END));
        de_d    = (h_d < 12'(H_ACTIVE)) && (v_d < 11'(V_ACTIVE));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q         <= '0;
            hd_clk_q      <= 1'b0;
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            de_q          <= 1'b1;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            lock_req_q    <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            hd_clk_q      <= hd_clk_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            lock_req_q    <= lock_req_d;
        end
    end

    assign o_hd_clk      = hd_clk_q;
    assign o_hd_hsync    = hsync_q;
    assign o_hd_vsync    = vsync_q;
    assign o_hd_de       = de_q;
    assign o_h_count     = h_q;
    assign o_v_count     = v_q;
    assign o_frame_start = frame_start_q;
    assign o_locked      = locked_q;

endmodule

// File: tb/tb_hd_timing_gen.sv
// tb/tb_hd_timing_gen.sv - self-checking bench for hd_timing_gen
module tb_hd_timing_gen;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int LOCK = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic i_frame_end = 1'b0;
    logic i_lock_en = 1'b0;

    logic        a_hd_clk, a_hsync, a_vsync, a_de, a_fs, a_locked;
    logic [11:0] a_h;
    logic [10:0] a_v;
    logic        b_hd_clk, b_hsync, b_vsync, b_de, b_fs, b_locked;
    logic [11:0] b_h;
    logic [10:0] b_v;

    hd_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIX_INC(1), .PIX_MOD(1), .LOCK_LINE(LOCK)
    ) u_a (
        .clk(clk), .reset(reset), .i_frame_end(i_frame_end), .i_lock_en(i_lock_en),
        .o_hd_clk(a_hd_clk), .o_hd_hsync(a_hsync), .o_hd_vsync(a_vsync), .o_hd_de(a_de),
        .o_h_count(a_h), .o_v_count(a_v), .o_frame_start(a_fs), .o_locked(a_locked)
    );

    hd_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIX_INC(1), .PIX_MOD(3), .LOCK_LINE(LOCK)
    ) u_b (
        .clk(clk), .reset(reset), .i_frame_end(i_frame_end), .i_lock_en(i_lock_en),
        .o_hd_clk(b_hd_clk), .o_hd_hsync(b_hsync), .o_hd_vsync(b_vsync), .o_hd_de(b_de),
        .o_h_count(b_h), .o_v_count(b_v), .o_frame_start(b_fs), .o_locked(b_locked)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: raster position as a single pixel index within the frame,
    // strobe derived from the total tick count since reset.
    longint m_n[2];
    int     m_p[2];
    bit     m_hdclk[2], m_req[2], m_locked[2], m_fs[2];
    int     m_inc[2] = '{1, 1};
    int     m_mod[2] = '{1, 3};
    bit     m_valid = 1'b0;
    int     cyc = 0;

    task automatic model_step(input int k, input bit r, input bit fe, input bit le);
        longint t_now, t_prev;
        bit adv, lend, pend;
        int vn;
        if (r) begin
            m_n[k] = 0; m_p[k] = 0; m_hdclk[k] = 0;
            m_req[k] = 0; m_locked[k] = 0; m_fs[k] = 0;
        end else begin
            m_n[k]++;
            t_now  = (m_n[k] * m_inc[k]) / m_mod[k];
            t_prev = ((m_n[k] - 1) * m_inc[k]) / m_mod[k];
            m_hdclk[k] = t_now[0];
            adv  = (t_now != t_prev) && (t_now % 2 == 0);
            pend = m_req[k] | fe;
            lend = adv && (m_p[k] % HT == HT - 1);
            m_fs[k] = 0;
            if (adv) begin
                if (lend) begin
                    vn = (m_p[k] / HT + 1) % VT;
                    if (pend && le) begin
                        m_locked[k] = (vn == LOCK);
                        vn = LOCK;
                    end
                    m_p[k] = vn * HT;
                end else begin
                    m_p[k]++;
                end
                m_fs[k] = (m_p[k] == 0);
            end
            m_req[k] = le && !lend && pend;
        end
    endtask

    task automatic cmp(input int k, input logic hdclk, input logic hs, input logic vs,
                       input logic de, input logic fs, input logic lk,
                       input logic [11:0] h, input logic [10:0] v);
        int eh, ev;
        eh = m_p[k] % HT;
        ev = m_p[k] / HT;
        chk($sformatf("u%0d cyc%0d hd_clk", k, cyc), int'(hdclk), int'(m_hdclk[k]));
        chk($sformatf("u%0d cyc%0d h", k, cyc), int'(h), eh);
        chk($sformatf("u%0d cyc%0d v", k, cyc), int'(v), ev);
        chk($sformatf("u%0d cyc%0d hsync", k, cyc), int'(hs),
            int'(eh >= HA + HF && eh < HA + HF + HS));
        chk($sformatf("u%0d cyc%0d vsync", k, cyc), int'(vs),
            int'(ev >= VA + VF && ev < VA + VF + VS));
        chk($sformatf("u%0d cyc%0d de", k, cyc), int'(de), int'(eh < HA && ev < VA));
        chk($sformatf("u%0d cyc%0d frame_start", k, cyc), int'(fs), int'(m_fs[k]));
        chk($sformatf("u%0d cyc%0d locked", k, cyc), int'(lk), int'(m_locked[k]));
    endtask

    initial begin
        bit r, f, l;
        forever begin
            @(posedge clk);
            r = reset;
            f = i_frame_end;
            l = i_lock_en;
            model_step(0, r, f, l);
            model_step(1, r, f, l);
            if (r) begin
                m_valid = 1'b1;
                cyc = 0;
            end else begin
                cyc++;
            end
            #1;
            if (m_valid) begin
                cmp(0, a_hd_clk, a_hsync, a_vsync, a_de, a_fs, a_locked, a_h, a_v);
                cmp(1, b_hd_clk, b_hsync, b_vsync, b_de, b_fs, b_locked, b_h, b_v);
            end
        end
    end

    task automatic goto_cyc(input int c);
        int guard;
        guard = 0;
        while (cyc != c && guard < 1000) begin
            @(posedge clk);
            #2;
            guard++;
        end
        chk($sformatf("reach cyc %0d", c), cyc, c);
    endtask

    task automatic wait_hv(input int vv, input int hh, input bit need_hi, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (int'(a_v) == vv && int'(a_h) == hh && (!need_hi || a_hd_clk)) found = 1'b1;
        end
        chk({name, " position reached"}, int'(found), 1);
    endtask

    task automatic wait_vchange(input int from, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (int'(a_v) != from) found = 1'b0 | 1'b1;
        end
        chk({name, " line end seen"}, int'(found), 1);
    endtask

    task automatic pulse_fe();
        i_frame_end = 1'b1;
        @(negedge clk);
        i_frame_end = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset h", int'(a_h), 0);
        chk("reset v", int'(a_v), 0);
        chk("reset hd_clk", int'(a_hd_clk), 0);
        chk("reset de", int'(a_de), 1);
        chk("reset hsync", int'(a_hsync), 0);
        chk("reset vsync", int'(a_vsync), 0);
        chk("reset frame_start", int'(a_fs), 0);
        chk("reset locked", int'(a_locked), 0);
        chk("reset u1 de", int'(b_de), 1);
        reset = 1'b0;

        // free run, literal anchors
        goto_cyc(1);
        chk("cyc1 hd_clk", int'(a_hd_clk), 1);
        chk("cyc1 h", int'(a_h), 0);
        goto_cyc(2);
        chk("cyc2 hd_clk", int'(a_hd_clk), 0);
        chk("cyc2 h", int'(a_h), 1);
        chk("cyc2 u1 hd_clk", int'(b_hd_clk), 0);
        goto_cyc(3);
        chk("cyc3 u1 hd_clk", int'(b_hd_clk), 1);
        goto_cyc(20);
        chk("cyc20 h", int'(a_h), 10);
        chk("cyc20 hsync", int'(a_hsync), 1);
        chk("cyc20 de", int'(a_de), 0);
        goto_cyc(83);
        chk("cyc83 u1 h", int'(b_h), 13);
        chk("cyc83 u1 v", int'(b_v), 0);
        goto_cyc(84);
        chk("cyc84 u1 h", int'(b_h), 0);
        chk("cyc84 u1 v", int'(b_v), 1);
        goto_cyc(140);
        chk("cyc140 v", int'(a_v), 5);
        chk("cyc140 vsync", int'(a_vsync), 1);
        goto_cyc(195);
        chk("cyc195 frame_start", int'(a_fs), 0);
        goto_cyc(196);
        chk("cyc196 frame_start", int'(a_fs), 1);
        chk("cyc196 h", int'(a_h), 0);
        chk("cyc196 v", int'(a_v), 0);

        // frame-end pulses with lock disabled leave the raster alone
        wait_hv(1, 5, 1'b0, "nolock v1");
        pulse_fe();
        wait_vchange(1, "nolock v1");
        chk("nolock v1 next v", int'(a_v), 2);
        chk("nolock v1 locked", int'(a_locked), 0);
        wait_hv(2, 5, 1'b0, "nolock v2");
        i_frame_end = 1'b1;
        @(negedge clk);
        i_frame_end = 1'b0;
        i_lock_en = 1'b1;
        wait_vchange(2, "late enable");
        chk("late enable next v", int'(a_v), 3);
        chk("late enable locked", int'(a_locked), 0);

        // frame end coincident with the last pixel advance of line 3
        wait_hv(3, 13, 1'b1, "coincident");
        pulse_fe();
        chk("coincident v", int'(a_v), 0);
        chk("coincident h", int'(a_h), 0);
        chk("coincident frame_start", int'(a_fs), 1);
        chk("coincident locked", int'(a_locked), 0);

        // double pulse on line 2 -> single jump to line 0
        wait_hv(2, 5, 1'b0, "lock v2");
        pulse_fe();
        wait_hv(2, 7, 1'b0, "lock v2 second");
        pulse_fe();
        wait_vchange(2, "lock v2");
        chk("lock v2 next v", int'(a_v), 0);
        chk("lock v2 frame_start", int'(a_fs), 1);
        chk("lock v2 locked", int'(a_locked), 0);

        // pulse on the last line: already in phase
        wait_hv(6, 5, 1'b0, "lock v6");
        pulse_fe();
        wait_vchange(6, "lock v6");
        chk("lock v6 next v", int'(a_v), 0);
        chk("lock v6 frame_start", int'(a_fs), 1);
        chk("lock v6 locked", int'(a_locked), 1);

        // one-cycle reset mid-frame
        wait_hv(3, 6, 1'b0, "midreset");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset h", int'(a_h), 0);
        chk("midreset v", int'(a_v), 0);
        chk("midreset hd_clk", int'(a_hd_clk), 0);
        chk("midreset de", int'(a_de), 1);
        chk("midreset locked", int'(a_locked), 0);
        repeat (60) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
